// File: rtl/led_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// led_ctrl_pkg
//
// Shared definitions for the LED mode sequencer: mode code width, the legal
// mode codes, and small helpers for legality checking and cyclic advance.
// Codes above MODE_LAST are illegal and are never loaded into the mode register.
// -----------------------------------------------------------------------------
package led_ctrl_pkg;

    localparam int MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_OFF       = 3'd0;
    localparam mode_t MODE_SOLID     = 3'd1;
    localparam mode_t MODE_BLINK_1HZ = 3'd2;
    localparam mode_t MODE_BLINK_4HZ = 3'd3;
    localparam mode_t MODE_HEARTBEAT = 3'd4;
    localparam mode_t MODE_LAST      = MODE_HEARTBEAT;

    // True for codes that name a real display mode.
    function automatic logic mode_is_legal(input mode_t m);
        return (m <= MODE_LAST);
    endfunction

    // Button advance order: OFF -> SOLID -> ... -> HEARTBEAT -> OFF.
    function automatic mode_t mode_next(input mode_t m);
        return (m >= MODE_LAST) ? MODE_OFF : mode_t'(m + mode_t'(1));
    endfunction

endpackage

// File: rtl/led_mode_sequencer_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Debounces a raw asynchronous push button and emits a one-cycle pulse on each
// accepted press.
//
// The raw input goes through a 2-FF synchronizer. The debounced level only
// changes after DEBOUNCE_CYC consecutive synchronized samples that differ from
// the current debounced level; any sample equal to the current level restarts
// the count, so bounces shorter than DEBOUNCE_CYC are ignored.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset (debounced level cleared to 0)
//   btn_raw  in   raw button, active-high, asynchronous
//   rise     out  one-cycle pulse in the cycle the debounced level becomes 1
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_250_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic rise
);

    // Counter holds 0..DEBOUNCE_CYC-1; keep at least one bit for tiny values.
    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: reset is synchronous here, so rst_n is just another data input
    // sampled at the clock edge and must not appear in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise     <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
            rise   <= 1'b0;
            if (sync_q[1] == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // This sample completes the run of differing samples.
                stable_q <= sync_q[1];
                cnt_q    <= '0;
                rise     <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_mode_sequencer.sv
// -----------------------------------------------------------------------------
// led_mode_sequencer
//
// Sequences the board LED through OFF, SOLID, 1 Hz blink, 4 Hz blink and
// heartbeat. The mode is advanced by a debounced push button or written
// directly through a valid-only config port (no backpressure). The block owns
// the TICK_HZ timebase and the 3-bit pattern phase (8 ticks per frame).
//
// Any accepted mode change (including rewriting the current mode) restarts the
// prescaler and phase at 0. A legal config write beats a same-cycle button
// press; an illegal config write pulses cfg_err and lets the press through.
//
// Optional build macro: LED_PWM_DIM_EN
//   Defined   - a free-running 4-bit PWM counter dims the LED to DIM_DUTY/16.
//   Undefined - the LED follows the pattern on-condition directly.
//
// Ports:
//   clk        in   system clock
//   rst_btn    in   synchronous active-low reset
//   mode_btn   in   raw asynchronous push button, active-high
//   cfg_valid  in   direct mode write request
//   cfg_mode   in   requested mode code
//   cfg_err    out  one-cycle pulse after a write with an illegal code
//   mode       out  current mode code
//   tick       out  one-cycle pulse per pattern tick
//   LED        out  registered LED drive
// -----------------------------------------------------------------------------
module led_mode_sequencer
    import led_ctrl_pkg::*;
#(
    parameter int CLK_HZ       = 125_000_000,
    parameter int TICK_HZ      = 8,
    parameter int DEBOUNCE_CYC = 1_250_000,
    parameter int RESET_MODE   = 2,
    parameter int DIM_DUTY     = 4
) (
    input  logic              clk,
    input  logic              rst_btn,
    input  logic              mode_btn,
    input  logic              cfg_valid,
    input  logic [MODE_W-1:0] cfg_mode,
    output logic              cfg_err,
    output logic [MODE_W-1:0] mode,
    output logic              tick,
    output logic              LED
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PRESC_W  = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic btn_rise;

    mode_t              mode_q,  mode_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [2:0]         phase_q, phase_d;
    logic               cfg_legal;
    logic               pattern_on;
    logic               dim_gate;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn_debounce (
        .clk     (clk),
        .rst_n   (rst_btn),
        .btn_raw (mode_btn),
        .rise    (btn_rise)
    );

    // State register: mode, prescaler and pattern phase.
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the values that were present before the edge.
    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            mode_q  <= mode_t'(RESET_MODE);
            presc_q <= '0;
            phase_q <= '0;
        end else begin
            mode_q  <= mode_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
        end
    end

    // Next state: mode source arbitration and timebase.
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        cfg_legal = cfg_valid && mode_is_legal(cfg_mode);
        mode_d    = mode_q;
        presc_d   = presc_q;
        phase_d   = phase_q;

        if (cfg_legal) begin
            mode_d = cfg_mode;
        end else if (btn_rise) begin
            mode_d = mode_next(mode_q);
        end

        if (cfg_legal || btn_rise) begin
            presc_d = '0;
            phase_d = '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            phase_d = phase_q + 3'd1;
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    // Output decode: pattern on-condition from the current mode and phase.
    always_comb begin
        pattern_on = 1'b0;
        case (mode_q)
            MODE_OFF:       pattern_on = 1'b0;
            MODE_SOLID:     pattern_on = 1'b1;
            MODE_BLINK_1HZ: pattern_on = (phase_q < 3'd4);
            MODE_BLINK_4HZ: pattern_on = ~phase_q[0];
            MODE_HEARTBEAT: pattern_on = (phase_q == 3'd0) || (phase_q == 3'd2);
            default:        pattern_on = 1'b0;
        endcase
    end

`ifdef LED_PWM_DIM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    // Compared as int so DIM_DUTY=0 is always off and DIM_DUTY>=16 always on.
    assign dim_gate = (int'(pwm_cnt) < DIM_DUTY);
`else
    assign dim_gate = 1'b1;
`endif

    // Registered outputs. tick follows the prescaler's last count by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            tick    <= 1'b0;
            LED     <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            tick    <= (presc_q == PRESC_LAST);
            LED     <= pattern_on && dim_gate;
            cfg_err <= cfg_valid && !mode_is_legal(cfg_mode);
        end
    end

    assign mode = mode_q;

endmodule
